// File: rtl/dice_roll_ctrl.sv
// Die-select arbitration, shared debounce timer and roll/settle step sequencer.
// Optional macro DICE_CTRL_LFSR_EN lengthens the settle train by a pseudo-random 0..3 steps.
module dice_roll_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 327,
  parameter int unsigned STEP_DIV     = 64,
  parameter int unsigned SETTLE_STEPS = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] btn,
  output logic [5:0] die_sel_o,
  output logic       load_o,
  output logic       step_o,
  output logic       rolling_o,
  output logic       done_o
);

`ifdef DICE_CTRL_LFSR_EN
  localparam int unsigned MAX_STEPS = SETTLE_STEPS + 3;
`else
  localparam int unsigned MAX_STEPS = SETTLE_STEPS;
`endif
  localparam int unsigned IW = $clog2(STEP_DIV << (MAX_STEPS + 1));
  localparam int unsigned TW = $clog2(DEBOUNCE_CYC);
  localparam int unsigned DW = $clog2(STEP_DIV);
  localparam int unsigned NW = $clog2(MAX_STEPS + 1);

  typedef enum logic [2:0] {IDLE, DEBOUNCE, ROLL, SETTLE, SHOW} state_t;

  state_t          state_q, state_d;
  logic [2:0]      cand_q, cand_d, pick;
  logic [TW-1:0]   timer_q, timer_d;
  logic [DW-1:0]   div_q, div_d;
  logic [IW-1:0]   ival_q, ival_d, icnt_q, icnt_d;
  logic [NW-1:0]   n_q, n_d, target;
  logic [5:0]      sel_d;
  logic            load_d, step_d, rolling_d, done_d;

`ifdef DICE_CTRL_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic [1:0] extra_q, extra_d;
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign target = NW'(SETTLE_STEPS) + NW'(extra_q);
`else
  assign target = NW'(SETTLE_STEPS);
`endif

  // Lowest index wins.
  always_comb begin
    pick = 3'd0;
    if      (btn[0]) pick = 3'd0;
    else if (btn[1]) pick = 3'd1;
    else if (btn[2]) pick = 3'd2;
    else if (btn[3]) pick = 3'd3;
    else if (btn[4]) pick = 3'd4;
    else if (btn[5]) pick = 3'd5;
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    timer_d = timer_q;
    div_d   = div_q;
    ival_d  = ival_q;
    icnt_d  = icnt_q;
    n_d     = n_q;
    sel_d   = die_sel_o;
    load_d  = 1'b0;
    step_d  = 1'b0;
    done_d  = 1'b0;
`ifdef DICE_CTRL_LFSR_EN
    extra_d = extra_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (btn != 6'd0) begin
          cand_d  = pick;
          timer_d = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!btn[cand_q]) begin
          state_d = IDLE;
        end else if (timer_q == TW'(DEBOUNCE_CYC - 1)) begin
          sel_d   = 6'b000001 << cand_q;
          load_d  = 1'b1;
          div_d   = '0;
          state_d = ROLL;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ROLL: begin
        // The wrap step is still issued on the same edge that sees the release.
        if (div_q == DW'(STEP_DIV - 1)) begin
          step_d = 1'b1;
          div_d  = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
        if (!btn[cand_q]) begin
          ival_d  = IW'(2 * STEP_DIV);
          icnt_d  = '0;
          n_d     = '0;
          state_d = SETTLE;
`ifdef DICE_CTRL_LFSR_EN
          extra_d = lfsr_q[1:0];
`endif
        end
      end
      SETTLE: begin
        if (icnt_q == ival_q - 1'b1) begin
          step_d = 1'b1;
          n_d    = n_q + 1'b1;
          ival_d = ival_q << 1;
          icnt_d = '0;
          if (n_d == target) begin
            done_d  = 1'b1;
            state_d = SHOW;
          end
        end else begin
          icnt_d = icnt_q + 1'b1;
        end
      end
      SHOW: begin
        if (btn == 6'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rolling_d = (state_d == ROLL) || (state_d == SETTLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cand_q    <= '0;
      timer_q   <= '0;
      div_q     <= '0;
      ival_q    <= '0;
      icnt_q    <= '0;
      n_q       <= '0;
      die_sel_o <= '0;
      load_o    <= 1'b0;
      step_o    <= 1'b0;
      rolling_o <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      timer_q   <= timer_d;
      div_q     <= div_d;
      ival_q    <= ival_d;
      icnt_q    <= icnt_d;
      n_q       <= n_d;
      die_sel_o <= sel_d;
      load_o    <= load_d;
      step_o    <= step_d;
      rolling_o <= rolling_d;
      done_o    <= done_d;
    end
  end

`ifdef DICE_CTRL_LFSR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q  <= 8'h01;
      extra_q <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      extra_q <= extra_d;
    end
  end
`endif

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Bench for dice_roll_ctrl: timeline model (absolute edge schedule) checked every cycle,
// plus directed scenarios with literal edge expectations.
module tb_dice_roll_ctrl;
  localparam int D = 4;
  localparam int S = 4;
  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] btn = 6'd0;
  logic [5:0] die_sel_o;
  logic       load_o, step_o, rolling_o, done_o;

  dice_roll_ctrl #(.DEBOUNCE_CYC(D), .STEP_DIV(S), .SETTLE_STEPS(N)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .die_sel_o(die_sel_o),
    .load_o(load_o), .step_o(step_o), .rolling_o(rolling_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit ld_at[0:4095];
  bit st_at[0:4095];
  bit dn_at[0:4095];
  bit rl_at[0:4095];

  task automatic cmp(input string nm, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int cnt(input int kind, input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++)
      c += (kind == 0) ? int'(ld_at[i]) : (kind == 1) ? int'(st_at[i]) : int'(dn_at[i]);
    return c;
  endfunction

  // Model: 0 idle, 1 pressed, 2 rolling, 3 settling, 4 showing; times are absolute edges.
  int mode = 0, cand = 0, press = 0, rstart = 0, rel = 0, k = 0;
  logic [5:0] e_sel = 6'd0;
  logic e_ld, e_st, e_dn, e_rl;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      e_ld = 1'b0; e_st = 1'b0; e_dn = 1'b0;
      if (!rst_n) begin
        mode = 0;
        e_sel = 6'd0;
      end else begin
        case (mode)
          0: if (btn != 6'd0) begin
               for (int i = 5; i >= 0; i--) if (btn[i]) cand = i;
               press = cyc;
               mode = 1;
             end
          1: if (!btn[cand]) mode = 0;
             else if (cyc - press == D) begin
               e_sel = 6'd1 << cand;
               e_ld = 1'b1;
               rstart = cyc;
               mode = 2;
             end
          2: begin
               if ((cyc - rstart) % S == 0) e_st = 1'b1;
               if (!btn[cand]) begin
                 rel = cyc;
                 k = 1;
                 mode = 3;
               end
             end
          3: if (cyc == rel + 2 * S * ((1 << k) - 1)) begin
               e_st = 1'b1;
               if (k == N) begin
                 e_dn = 1'b1;
                 mode = 4;
               end
               k++;
             end
          default: if (btn == 6'd0) mode = 0;
        endcase
      end
      e_rl = (mode == 2) || (mode == 3);
      #1;
      ld_at[cyc] = (load_o === 1'b1);
      st_at[cyc] = (step_o === 1'b1);
      dn_at[cyc] = (done_o === 1'b1);
      rl_at[cyc] = (rolling_o === 1'b1);
      cmp("die_sel_o", die_sel_o, e_sel);
      cmp("load_o", {5'd0, load_o}, {5'd0, e_ld});
      cmp("step_o", {5'd0, step_o}, {5'd0, e_st});
      cmp("done_o", {5'd0, done_o}, {5'd0, e_dn});
      cmp("rolling_o", {5'd0, rolling_o}, {5'd0, e_rl});
    end
  end

  task automatic at_neg(input int target);
    while (cyc < target - 1) @(negedge clk);
  endtask

  int base;

  initial begin
    // Reset with all buttons pressed
    rst_n = 1'b0; btn = 6'h3F;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("rst_outputs", {die_sel_o[0] | die_sel_o[1] | die_sel_o[2] | die_sel_o[3] | die_sel_o[4] | die_sel_o[5],
                        load_o, step_o, rolling_o, done_o, 1'b0}, 6'd0);
    rst_n = 1'b1; btn = 6'd0;
    base = cyc + 1;
    at_neg(base + 50);
    cmp("idle_pulses", 6'(cnt(0, base, base + 49) + cnt(1, base, base + 49) + cnt(2, base, base + 49)), 6'd0);

    // Bounce on btn[2]
    base = cyc + 1;
    btn = 6'b000100;
    at_neg(base + 3); btn = 6'd0;
    at_neg(base + 12);
    cmp("bounce_loads", 6'(cnt(0, base, base + 11)), 6'd0);
    cmp("bounce_sel", die_sel_o, 6'd0);

    // Priority: btn[2] beats btn[3]
    base = cyc + 1;
    btn = 6'b001100;
    at_neg(base + 6);
    cmp("prio_load_edge4", {5'd0, ld_at[base + 4]}, 6'd1);
    cmp("prio_load_count", 6'(cnt(0, base, base + 5)), 6'd1);
    cmp("prio_sel", die_sel_o, 6'b000100);
    btn = 6'd0;
    at_neg(base + 72);

    // Full roll on btn[1], btn[5] blip during ROLL
    base = cyc + 1;
    btn = 6'b000010;
    at_neg(base + 9);  btn = 6'b100010;
    at_neg(base + 12); btn = 6'b000010;
    at_neg(base + 18); btn = 6'd0;
    at_neg(base + 80);
    cmp("roll_load_edge4", {5'd0, ld_at[base + 4]}, 6'd1);
    cmp("roll_sel", die_sel_o, 6'b000010);
    cmp("roll_step8", {5'd0, st_at[base + 8]}, 6'd1);
    cmp("roll_step12", {5'd0, st_at[base + 12]}, 6'd1);
    cmp("roll_step16", {5'd0, st_at[base + 16]}, 6'd1);
    cmp("settle_step26", {5'd0, st_at[base + 26]}, 6'd1);
    cmp("settle_step42", {5'd0, st_at[base + 42]}, 6'd1);
    cmp("settle_step74", {5'd0, st_at[base + 74]}, 6'd1);
    cmp("step_count", 6'(cnt(1, base, base + 79)), 6'd6);
    cmp("done_edge74", {5'd0, dn_at[base + 74]}, 6'd1);
    cmp("done_count", 6'(cnt(2, base, base + 79)), 6'd1);
    cmp("rolling_span", {2'd0, rl_at[base + 3], rl_at[base + 4], rl_at[base + 73], rl_at[base + 74]}, 6'b000110);

    // btn[0] held through SHOW blocks return to IDLE
    base = cyc + 1;
    btn = 6'b000001;
    at_neg(base + 18); btn = 6'd0;
    at_neg(base + 40); btn = 6'b000001;
    at_neg(base + 90); btn = 6'd0;
    at_neg(base + 110);
    cmp("hold_sel", die_sel_o, 6'b000001);
    cmp("hold_step42", {5'd0, st_at[base + 42]}, 6'd1);
    cmp("hold_done74", {5'd0, dn_at[base + 74]}, 6'd1);
    cmp("hold_no_retrigger", 6'(cnt(0, base + 75, base + 109)), 6'd0);

    // Reset mid-SETTLE
    base = cyc + 1;
    btn = 6'b000010;
    at_neg(base + 18); btn = 6'd0;
    at_neg(base + 30); rst_n = 1'b0;
    at_neg(base + 31); rst_n = 1'b1;
    at_neg(base + 60);
    cmp("pre_rst_step26", {5'd0, st_at[base + 26]}, 6'd1);
    cmp("post_rst_steps", 6'(cnt(1, base + 30, base + 59)), 6'd0);
    cmp("post_rst_rolling", {5'd0, rl_at[base + 30]}, 6'd0);
    cmp("post_rst_sel", die_sel_o, 6'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
